// File: rtl/dsc_cache_ctrl.sv
// Descriptor cache controller: circular-buffer writes into a DEPTH x DATA_W SRAM, in-order reads
// through the 2-cycle SRAM pipeline into a 3-entry skid buffer feeding the channel engine.
module dsc_cache_ctrl #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned AW     = $clog2(DEPTH),
  parameter int unsigned LW     = $clog2(DEPTH + 4)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FLUSH,
  input  logic              S_VALID,
  output logic              S_READY,
  input  logic [DATA_W-1:0] S_DATA,
  output logic              M_VALID,
  input  logic              M_READY,
  output logic [DATA_W-1:0] M_DATA,
  output logic              W_EN,
  output logic [AW-1:0]     W_ADDR,
  output logic [DATA_W-1:0] W_DATA,
  output logic [AW-1:0]     R_ADDR,
  output logic              R_ADDR_EN,
  output logic              R_DATA_EN,
  input  logic [DATA_W-1:0] R_DATA,
  output logic [LW-1:0]     LEVEL
);

  localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          s1_q, s1_d, s2_q, s2_d;
  logic [1:0]    skid_cnt_q, skid_cnt_d, skid_fill;
  logic [2:0][DATA_W-1:0] skid_q, skid_d;
  logic          m_valid_q;
  logic [LW-1:0] level_q, level_d;

  logic          s_ready, accept, pop, issue;
  logic [2:0]    in_use;

  // Read credit counts every word already committed to the skid: in flight plus held.
  always_comb begin
    s_ready = (cnt_q != FullCnt) & ~FLUSH;
    accept  = S_VALID & s_ready;
    pop     = m_valid_q & M_READY;
    in_use  = {2'b00, s1_q} + {2'b00, s2_q} + {1'b0, skid_cnt_q} - {2'b00, pop};
    issue   = (cnt_q != '0) & (in_use < 3'd3) & ~FLUSH;
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q + AW'(accept);
    rd_ptr_d  = rd_ptr_q + AW'(issue);
    cnt_d     = cnt_q + (AW + 1)'(accept) - (AW + 1)'(issue);
    s1_d      = issue;
    s2_d      = s1_q;
    skid_d    = skid_q;
    skid_fill = skid_cnt_q;
    if (pop) begin
      skid_d[0] = skid_q[1];
      skid_d[1] = skid_q[2];
      skid_fill = skid_cnt_q - 2'd1;
    end
    skid_cnt_d = skid_fill;
    if (s2_q) begin
      case (skid_fill)
        2'd0:    skid_d[0] = R_DATA;
        2'd1:    skid_d[1] = R_DATA;
        2'd2:    skid_d[2] = R_DATA;
        default: ;
      endcase
      skid_cnt_d = skid_fill + 2'd1;
    end
    // Flush drops queue state and in-flight reads but leaves the data registers alone.
    if (FLUSH) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      cnt_d      = '0;
      s1_d       = 1'b0;
      s2_d       = 1'b0;
      skid_cnt_d = '0;
    end
    level_d = LW'(cnt_d) + LW'(s1_d) + LW'(s2_d) + LW'(skid_cnt_d);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      skid_cnt_q <= '0;
      skid_q     <= '0;
      m_valid_q  <= 1'b0;
      level_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      skid_cnt_q <= skid_cnt_d;
      skid_q     <= skid_d;
      m_valid_q  <= (skid_cnt_d != '0);
      level_q    <= level_d;
    end
  end

  always_comb begin
    S_READY   = s_ready;
    W_EN      = accept;
    W_ADDR    = wr_ptr_q;
    W_DATA    = S_DATA;
    R_ADDR    = rd_ptr_q;
    R_ADDR_EN = issue;
    R_DATA_EN = s1_q;
    M_VALID   = m_valid_q;
    M_DATA    = skid_q[0];
    LEVEL     = level_q;
  end

endmodule

// File: tb/tb_dsc_cache_ctrl.sv
// Directed and random-stall bench for dsc_cache_ctrl with a behavioural
// registered-address / registered-data SRAM model.
module tb_dsc_cache_ctrl;

  logic        CLK = 1'b0;
  logic        RESET, FLUSH, S_VALID, S_READY, M_VALID, M_READY;
  logic        W_EN, R_ADDR_EN, R_DATA_EN;
  logic [63:0] S_DATA, M_DATA, W_DATA, R_DATA;
  logic [1:0]  W_ADDR, R_ADDR;
  logic [2:0]  LEVEL;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  dsc_cache_ctrl #(.DEPTH(4), .DATA_W(64)) dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
    .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA),
    .M_VALID(M_VALID), .M_READY(M_READY), .M_DATA(M_DATA),
    .W_EN(W_EN), .W_ADDR(W_ADDR), .W_DATA(W_DATA),
    .R_ADDR(R_ADDR), .R_ADDR_EN(R_ADDR_EN), .R_DATA_EN(R_DATA_EN), .R_DATA(R_DATA),
    .LEVEL(LEVEL)
  );

  // SRAM: registered read address, registered read data
  logic [63:0] mem [4];
  logic [1:0]  sram_addr_q = 2'd0;
  logic [63:0] sram_rd_q = 64'd0;
  always @(posedge CLK) begin
    if (W_EN) mem[W_ADDR] <= W_DATA;
    if (R_ADDR_EN) sram_addr_q <= R_ADDR;
    if (R_DATA_EN) sram_rd_q <= mem[sram_addr_q];
  end
  assign R_DATA = sram_rd_q;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic apply_reset();
    @(posedge CLK); #1;
    RESET = 1'b1; S_VALID = 1'b0; M_READY = 1'b0; FLUSH = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; FLUSH = 1'b0; S_VALID = 1'b0; M_READY = 1'b0; S_DATA = '0;
    @(posedge CLK); @(posedge CLK); #1;
    checks++; if (M_VALID !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", M_VALID); end
    checks++; if (W_EN !== 1'b0) begin errors++; $display("FAIL reset_w_en: got %b want 0", W_EN); end
    checks++; if (R_ADDR_EN !== 1'b0) begin errors++; $display("FAIL reset_r_addr_en: got %b want 0", R_ADDR_EN); end
    checks++; if (R_DATA_EN !== 1'b0) begin errors++; $display("FAIL reset_r_data_en: got %b want 0", R_DATA_EN); end
    checks++; if (W_ADDR !== 2'd0) begin errors++; $display("FAIL reset_w_addr: got %0d want 0", W_ADDR); end
    checks++; if (R_ADDR !== 2'd0) begin errors++; $display("FAIL reset_r_addr: got %0d want 0", R_ADDR); end
    checks++; if (LEVEL !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", LEVEL); end
    checks++; if (S_READY !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b want 1", S_READY); end
    checks++; if (M_DATA !== 64'd0) begin errors++; $display("FAIL reset_m_data: got %h want 0", M_DATA); end
    RESET = 1'b0;
  endtask

  task automatic test_single_word();
    for (int c = 0; c <= 5; c++) begin
      @(posedge CLK); #1;
      S_VALID = (c == 0); S_DATA = 64'hA5A5_0000_0000_0001; M_READY = (c == 4);
      #1;
      checks++;
      if (LEVEL !== ((c >= 1 && c <= 4) ? 3'd1 : 3'd0)) begin
        errors++; $display("FAIL single_level c%0d: got %0d", c, LEVEL);
      end
      checks++;
      if (M_VALID !== 1'(c == 4)) begin
        errors++; $display("FAIL single_m_valid c%0d: got %b want %b", c, M_VALID, c == 4);
      end
      if (c == 0) begin
        checks++;
        if (W_EN !== 1'b1 || W_ADDR !== 2'd0 || W_DATA !== 64'hA5A5_0000_0000_0001) begin
          errors++; $display("FAIL single_write: got en=%b addr=%0d data=%h", W_EN, W_ADDR, W_DATA);
        end
      end
      if (c == 4) begin
        checks++;
        if (M_DATA !== 64'hA5A5_0000_0000_0001) begin
          errors++; $display("FAIL single_m_data: got %h want a5a5000000000001", M_DATA);
        end
      end
    end
    S_VALID = 1'b0; M_READY = 1'b0;
  endtask

  task automatic test_backpressure();
    int n_acc = 0;
    int got = 0;
    M_READY = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge CLK); #1;
      S_VALID = 1'b1; S_DATA = 64'h2000 + 64'(n_acc);
      #1;
      if (S_READY) n_acc++;
    end
    checks++; if (n_acc !== 7) begin errors++; $display("FAIL fill_accepts: got %0d want 7", n_acc); end
    checks++; if (LEVEL !== 3'd7) begin errors++; $display("FAIL fill_level: got %0d want 7", LEVEL); end
    checks++; if (S_READY !== 1'b0) begin errors++; $display("FAIL fill_s_ready: got %b want 0", S_READY); end
    @(posedge CLK); #1;
    S_VALID = 1'b0; M_READY = 1'b1;
    #1;
    checks++; if (S_READY !== 1'b0) begin errors++; $display("FAIL release_s_ready: got %b want 0", S_READY); end
    for (int c = 0; c < 20 && got < 7; c++) begin
      if (c > 0) begin @(posedge CLK); #2; end
      if (c == 1) begin
        checks++;
        if (S_READY !== 1'b1) begin errors++; $display("FAIL reassert_s_ready: got %b want 1", S_READY); end
      end
      if (M_VALID) begin
        checks++;
        if (M_DATA !== 64'h2000 + 64'(got)) begin
          errors++; $display("FAIL drain_order[%0d]: got %h want %h", got, M_DATA, 64'h2000 + 64'(got));
        end
        got++;
      end
    end
    checks++; if (got !== 7) begin errors++; $display("FAIL drain_count: got %0d want 7", got); end
    @(posedge CLK); #2;
    checks++; if (LEVEL !== 3'd0) begin errors++; $display("FAIL drain_level: got %0d want 0", LEVEL); end
    M_READY = 1'b0;
  endtask

  task automatic test_streaming();
    apply_reset();
    for (int c = 0; c <= 24; c++) begin
      @(posedge CLK); #1;
      S_VALID = (c < 20); S_DATA = 64'h1000 + 64'(c); M_READY = 1'b1;
      #1;
      if (c < 20) begin
        checks++;
        if (S_READY !== 1'b1 || W_EN !== 1'b1 || W_ADDR !== 2'(c % 4)) begin
          errors++; $display("FAIL stream_write c%0d: got rdy=%b en=%b addr=%0d want addr %0d", c, S_READY, W_EN, W_ADDR, c % 4);
        end
      end
      if (c >= 1 && c <= 20) begin
        checks++;
        if (R_ADDR_EN !== 1'b1 || R_ADDR !== 2'((c - 1) % 4)) begin
          errors++; $display("FAIL stream_read c%0d: got en=%b addr=%0d want addr %0d", c, R_ADDR_EN, R_ADDR, (c - 1) % 4);
        end
      end
      if (c >= 4 && c <= 23) begin
        checks++;
        if (M_VALID !== 1'b1 || M_DATA !== 64'h1000 + 64'(c - 4)) begin
          errors++; $display("FAIL stream_out c%0d: got v=%b data=%h want %h", c, M_VALID, M_DATA, 64'h1000 + 64'(c - 4));
        end
      end
      if (c == 24) begin
        checks++;
        if (M_VALID !== 1'b0 || LEVEL !== 3'd0) begin
          errors++; $display("FAIL stream_end: got v=%b level=%0d want 0/0", M_VALID, LEVEL);
        end
      end
    end
    S_VALID = 1'b0; M_READY = 1'b0;
  endtask

  task automatic test_flush();
    int seen = -1;
    apply_reset();
    for (int c = 0; c < 7; c++) begin
      @(posedge CLK); #1;
      S_VALID = 1'b1; S_DATA = 64'h5000 + 64'(c); M_READY = (c != 4);
      #1;
    end
    @(posedge CLK); #1;
    S_VALID = 1'b0; M_READY = 1'b0; FLUSH = 1'b1;
    #1;
    checks++; if (LEVEL !== 3'd5) begin errors++; $display("FAIL flush_pre_level: got %0d want 5", LEVEL); end
    checks++; if (S_READY !== 1'b0) begin errors++; $display("FAIL flush_s_ready: got %b want 0", S_READY); end
    @(posedge CLK); #1;
    FLUSH = 1'b0; S_VALID = 1'b1; S_DATA = 64'hBEEF;
    #1;
    checks++;
    if (LEVEL !== 3'd0 || M_VALID !== 1'b0 || S_READY !== 1'b1) begin
      errors++; $display("FAIL flush_post: got level=%0d v=%b rdy=%b want 0/0/1", LEVEL, M_VALID, S_READY);
    end
    for (int c = 1; c <= 8 && seen < 0; c++) begin
      @(posedge CLK); #1;
      S_VALID = 1'b0; M_READY = 1'b1;
      #1;
      if (M_VALID) begin
        seen = c;
        checks++;
        if (M_DATA !== 64'hBEEF) begin errors++; $display("FAIL flush_first: got %h want beef", M_DATA); end
      end
    end
    checks++; if (seen !== 4) begin errors++; $display("FAIL flush_latency: got %0d want 4", seen); end
    @(posedge CLK); #2;
    checks++; if (M_VALID !== 1'b0) begin errors++; $display("FAIL flush_stale: got v=%b want 0", M_VALID); end
    M_READY = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int c = 0; c <= 5; c++) begin
      @(posedge CLK); #1;
      S_VALID = 1'b1; S_DATA = 64'h3000 + 64'(c); M_READY = 1'b1;
      #1;
    end
    checks++; if (M_VALID !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got v=%b want 1", M_VALID); end
    #1;
    S_VALID = 1'b0; RESET = 1'b1;
    #1;
    checks++;
    if (M_VALID !== 1'b0 || W_EN !== 1'b0 || R_ADDR_EN !== 1'b0 || R_DATA_EN !== 1'b0) begin
      errors++; $display("FAIL rstmid_ctl: got v=%b wen=%b ren=%b den=%b want 0", M_VALID, W_EN, R_ADDR_EN, R_DATA_EN);
    end
    checks++;
    if (W_ADDR !== 2'd0 || R_ADDR !== 2'd0 || LEVEL !== 3'd0 || S_READY !== 1'b1 || M_DATA !== 64'd0) begin
      errors++; $display("FAIL rstmid_val: got wa=%0d ra=%0d lvl=%0d rdy=%b d=%h", W_ADDR, R_ADDR, LEVEL, S_READY, M_DATA);
    end
    @(posedge CLK); #2;
    RESET = 1'b0;
    for (int c = 0; c <= 5; c++) begin
      @(posedge CLK); #1;
      S_VALID = (c == 0); S_DATA = 64'h4000; M_READY = 1'b1;
      #1;
      checks++;
      if (M_VALID !== 1'(c == 4)) begin errors++; $display("FAIL rstmid_lat c%0d: got v=%b", c, M_VALID); end
      if (c == 4) begin
        checks++;
        if (M_DATA !== 64'h4000) begin errors++; $display("FAIL rstmid_data: got %h want 4000", M_DATA); end
      end
    end
    S_VALID = 1'b0; M_READY = 1'b0;
  endtask

  task automatic test_random_stall();
    logic [63:0] sb[$];
    logic [63:0] exp;
    int sent = 0;
    int got = 0;
    int level_m = 0;
    apply_reset();
    for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
      @(posedge CLK); #1;
      S_VALID = (sent < 1000) && ($urandom_range(0, 3) != 0);
      S_DATA = {32'hCAFE_0000, 32'(sent)};
      M_READY = ($urandom_range(0, 2) != 0);
      #1;
      checks++;
      if (LEVEL !== 3'(level_m)) begin errors++; $display("FAIL rand_level cyc%0d: got %0d want %0d", cyc, LEVEL, level_m); end
      checks++;
      if (dut.s2_q && dut.skid_cnt_q == 2'd3 && !(M_VALID && M_READY)) begin
        errors++; $display("FAIL rand_skid_overflow cyc%0d: got push into full skid, want none", cyc);
      end
      if (S_VALID && S_READY) begin
        sb.push_back(S_DATA); sent++; level_m++;
      end
      if (M_VALID && M_READY) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL rand_underflow cyc%0d: got %h, want no word", cyc, M_DATA);
        end else begin
          exp = sb.pop_front();
          if (M_DATA !== exp) begin errors++; $display("FAIL rand_data[%0d]: got %h want %h", got, M_DATA, exp); end
        end
        got++; level_m--;
      end
    end
    checks++; if (got !== 1000) begin errors++; $display("FAIL rand_count: got %0d want 1000", got); end
    S_VALID = 1'b0; M_READY = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_backpressure();
    test_streaming();
    test_flush();
    test_reset_mid();
    test_random_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
